// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, mode and size definitions for the convolution path
package conv_pkg;

    localparam int A_LEN = 16;
    localparam int B_LEN = 9;

    localparam logic [1:0] MODE_STORE  = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_SA3    = 2'b10;
    localparam logic [1:0] MODE_SA2    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT
    } state_t;

    // One-hot start vector ordered {sa2, sa3, single, store}.
    function automatic logic [3:0] mode_onehot(input logic [1:0] mode);
        logic [3:0] v;
        v = 4'b0000;
        case (mode)
            MODE_STORE:  v = 4'b0001;
            MODE_SINGLE: v = 4'b0010;
            MODE_SA3:    v = 4'b0100;
            MODE_SA2:    v = 4'b1000;
            default:     v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/conv_operand_loader_if.sv
// rtl/conv_operand_loader_if.sv - operand byte stream handshake bundle
interface conv_operand_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_mode;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_mode,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_mode,
        output in_ready
    );

endinterface

// File: rtl/conv_operand_regs.sv
// rtl/conv_operand_regs.sv - 25 operand byte registers with indexed write into region A or B
module conv_operand_regs
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    sel_b,
    input  logic [3:0]              idx,
    input  logic [7:0]              data,
    output logic [A_LEN-1:0][7:0]   a_flat,
    output logic [B_LEN-1:0][7:0]   b_flat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_flat <= '0;
            b_flat <= '0;
        end else if (we) begin
            for (int i = 0; i < A_LEN; i++) begin
                if (!sel_b && idx == 4'(i)) a_flat[i] <= data;
            end
            for (int i = 0; i < B_LEN; i++) begin
                if (sel_b && idx == 4'(i)) b_flat[i] <= data;
            end
        end
    end

endmodule

// File: rtl/conv_operand_loader.sv
// rtl/conv_operand_loader.sv - assembles A/B operands from a byte stream and issues one mode start pulse per frame
module conv_operand_loader
    import conv_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    conv_operand_loader_if.slave        in_bus,
    input  logic                        computation_done,
    output logic [7:0]                  a11, a12, a13, a14,
    output logic [7:0]                  a21, a22, a23, a24,
    output logic [7:0]                  a31, a32, a33, a34,
    output logic [7:0]                  a41, a42, a43, a44,
    output logic [7:0]                  b11, b12, b13,
    output logic [7:0]                  b21, b22, b23,
    output logic [7:0]                  b31, b32, b33,
    output logic                        active_store,
    output logic                        active_single,
    output logic                        active_sa3,
    output logic                        active_sa2,
    output logic                        busy
);

    state_t                 state, state_n;
    logic [3:0]             cnt;
    logic [1:0]             mode_q;
    logic                   ready;
    logic                   take;
    logic [3:0]             start_vec;
    logic [A_LEN-1:0][7:0]  a_flat;
    logic [B_LEN-1:0][7:0]  b_flat;

    assign take = in_bus.in_valid & ready;
    assign in_bus.in_ready = ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (take) state_n = LOAD_A;
            LOAD_A:  if (take && cnt == 4'(A_LEN - 1)) state_n = LOAD_B;
            LOAD_B:  if (take && cnt == 4'(B_LEN - 1)) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (computation_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        start_vec = 4'b0000;
        case (state)
            IDLE:    ready = 1'b1;
            LOAD_A,
            LOAD_B: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            ISSUE: begin
                busy      = 1'b1;
                start_vec = mode_onehot(mode_q);
            end
            WAIT:    busy = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign {active_sa2, active_sa3, active_single, active_store} = start_vec;

    // Counter resets to zero on each terminal count so IDLE always writes index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 4'd0;
            mode_q <= MODE_STORE;
        end else if (take) begin
            case (state)
                IDLE: begin
                    cnt    <= 4'd1;
                    mode_q <= in_bus.in_mode;
                end
                LOAD_A:  cnt <= (cnt == 4'(A_LEN - 1)) ? 4'd0 : cnt + 4'd1;
                LOAD_B:  cnt <= (cnt == 4'(B_LEN - 1)) ? 4'd0 : cnt + 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    conv_operand_regs u_regs (
        .clk    (clk),
        .rst    (rst),
        .we     (take),
        .sel_b  (state == LOAD_B),
        .idx    ((state == IDLE) ? 4'd0 : cnt),
        .data   (in_bus.in_data),
        .a_flat (a_flat),
        .b_flat (b_flat)
    );

    assign a11 = a_flat[0];   assign a12 = a_flat[1];   assign a13 = a_flat[2];   assign a14 = a_flat[3];
    assign a21 = a_flat[4];   assign a22 = a_flat[5];   assign a23 = a_flat[6];   assign a24 = a_flat[7];
    assign a31 = a_flat[8];   assign a32 = a_flat[9];   assign a33 = a_flat[10];  assign a34 = a_flat[11];
    assign a41 = a_flat[12];  assign a42 = a_flat[13];  assign a43 = a_flat[14];  assign a44 = a_flat[15];
    assign b11 = b_flat[0];   assign b12 = b_flat[1];   assign b13 = b_flat[2];
    assign b21 = b_flat[3];   assign b22 = b_flat[4];   assign b23 = b_flat[5];
    assign b31 = b_flat[6];   assign b32 = b_flat[7];   assign b33 = b_flat[8];

endmodule

// File: tb/tb_conv_operand_loader.sv
// tb/tb_conv_operand_loader.sv - directed and randomized frames checked against a byte-array reference
module tb_conv_operand_loader;

    logic clk;
    logic rst;
    logic computation_done;
    logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
    logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
    logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic active_store, active_single, active_sa3, active_sa2, busy;

    int vectors;
    int miscompares;

    logic [7:0] frame [25];

    conv_operand_loader_if bus ();

    conv_operand_loader dut (
        .clk (clk), .rst (rst), .in_bus (bus), .computation_done (computation_done),
        .a11 (a11), .a12 (a12), .a13 (a13), .a14 (a14),
        .a21 (a21), .a22 (a22), .a23 (a23), .a24 (a24),
        .a31 (a31), .a32 (a32), .a33 (a33), .a34 (a34),
        .a41 (a41), .a42 (a42), .a43 (a43), .a44 (a44),
        .b11 (b11), .b12 (b12), .b13 (b13),
        .b21 (b21), .b22 (b22), .b23 (b23),
        .b31 (b31), .b32 (b32), .b33 (b33),
        .active_store (active_store), .active_single (active_single),
        .active_sa3 (active_sa3), .active_sa2 (active_sa2),
        .busy (busy)
    );

    wire [127:0] a_cat = {a44, a43, a42, a41, a34, a33, a32, a31,
                          a24, a23, a22, a21, a14, a13, a12, a11};
    wire [71:0]  b_cat = {b33, b32, b31, b23, b22, b21, b13, b12, b11};
    wire [3:0]   act   = {active_sa2, active_sa3, active_single, active_store};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_pulse(input logic [1:0] m);
        logic [3:0] v;
        v    = 4'b0000;
        v[m] = 1'b1;
        return v;
    endfunction

    task automatic check_operands(input string tag);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_a%0d%0d", tag, i / 4 + 1, i % 4 + 1), 128'(a_cat[i*8 +: 8]), 128'(frame[i]));
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_b%0d%0d", tag, i / 3 + 1, i % 3 + 1), 128'(b_cat[i*8 +: 8]), 128'(frame[16 + i]));
    endtask

    task automatic send_frame(input logic [1:0] m0, input logic [1:0] mrest, input bit gaps,
                              input bit done_noise, input bit done_in_issue,
                              input int wait_cycles, input int done_hold);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < 25 && guard < 1000) begin
            @(negedge clk);
            guard++;
            chk("load_ready", 128'(bus.in_ready), 128'(1));
            chk("load_busy", 128'(busy), 128'(i > 0));
            chk("load_active", 128'(act), 128'(0));
            computation_done = done_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gaps && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_mode  = 2'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = frame[i];
                bus.in_mode  = (i == 0) ? m0 : mrest;
                i++;
            end
        end
        chk("frame_complete", 128'(i), 128'(25));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'($urandom);
        chk("issue_active", 128'(act), 128'(exp_pulse(m0)));
        chk("issue_ready", 128'(bus.in_ready), 128'(0));
        chk("issue_busy", 128'(busy), 128'(1));
        computation_done = done_in_issue;
        @(negedge clk);
        computation_done = 1'b0;
        chk("wait_active", 128'(act), 128'(0));
        chk("wait_ready", 128'(bus.in_ready), 128'(0));
        chk("wait_busy", 128'(busy), 128'(1));
        check_operands("wait");
        for (int k = 0; k < wait_cycles; k++) begin
            @(negedge clk);
            chk("wait_hold_ready", 128'(bus.in_ready), 128'(0));
            chk("wait_hold_active", 128'(act), 128'(0));
        end
        computation_done = 1'b1;
        for (int k = 0; k < done_hold; k++) begin
            @(negedge clk);
            chk("done_ready", 128'(bus.in_ready), 128'(1));
            chk("done_busy", 128'(busy), 128'(0));
            chk("done_active", 128'(act), 128'(0));
        end
        computation_done = 1'b0;
        check_operands("idle");
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        rst              = 1'b1;
        computation_done = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = 8'h00;
        bus.in_mode      = 2'b00;
        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(bus.in_ready), 128'(1));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_active", 128'(act), 128'(0));
        chk("reset_a", 128'(a_cat), 128'(0));
        chk("reset_b", 128'(b_cat), 128'(0));
        rst = 1'b0;

        // back-to-back frame of bytes 1..25, mode single
        for (int i = 0; i < 25; i++) frame[i] = 8'(i + 1);
        send_frame(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2, 1);
        chk("b2b_a11", 128'(a11), 128'(1));
        chk("b2b_a44", 128'(a44), 128'(16));
        chk("b2b_b11", 128'(b11), 128'(17));
        chk("b2b_b33", 128'(b33), 128'(25));

        // gapped stream of the same data
        send_frame(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1, 1);

        // mode latched from byte 0 only
        for (int i = 0; i < 25; i++) frame[i] = 8'($urandom);
        send_frame(2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1);

        // done ignored in LOAD and ISSUE, held 3 cycles in WAIT
        for (int i = 0; i < 25; i++) frame[i] = 8'($urandom);
        send_frame(2'($urandom), 2'($urandom), 1'b0, 1'b1, 1'b1, 3, 3);

        // reset while byte 20 is presented
        for (int i = 0; i < 25; i++) frame[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = frame[i];
            bus.in_mode  = 2'b01;
        end
        @(negedge clk);
        bus.in_data = frame[20];
        rst = 1'b1;
        #1;
        chk("rst_async_busy", 128'(busy), 128'(0));
        chk("rst_async_a", 128'(a_cat), 128'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_active", 128'(act), 128'(0));
        chk("rst_a", 128'(a_cat), 128'(0));
        chk("rst_b", 128'(b_cat), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_active", 128'(act), 128'(0));

        // store then sa2 with descending data
        for (int i = 0; i < 25; i++) frame[i] = 8'($urandom);
        send_frame(2'b00, 2'($urandom), 1'b0, 1'b0, 1'b0, 1, 1);
        for (int i = 0; i < 25; i++) frame[i] = 8'(8'hFF - i);
        send_frame(2'b11, 2'($urandom), 1'b0, 1'b0, 1'b0, 1, 1);
        chk("desc_a11", 128'(a11), 128'(8'hFF));
        chk("desc_b33", 128'(b33), 128'(8'hE7));

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 25; i++) frame[i] = 8'($urandom);
            send_frame(2'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4), $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_operand_loader.md
# conv_operand_loader

Upstream stage of the convolution computation module. Accepts a byte stream over a valid/ready handshake and assembles the 4x4 input matrix A (a11..a44) and the 3x3 kernel B (b11..b33). It then issues a one-cycle start pulse on the selected mode line (store, single, sa3 or sa2) and holds all operands stable until the computation module reports completion.

## Interface

Parameters:
- none (sizes fixed: A_LEN = 16, B_LEN = 9, byte width 8)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream byte valid
- in_data  in  8  operand byte
- in_mode  in  2  mode select, sampled with first A byte: 00 store, 01 single, 10 sa3, 11 sa2
- in_ready  out  1  loader can accept a byte
- computation_done  in  1  completion from computation stage
- a11..a44  out  8 each  matrix A, registered
- b11..b33  out  8 each  kernel B, registered
- active_store, active_single, active_sa3, active_sa2  out  1 each  one-cycle start pulse, exactly one per frame
- busy  out  1  high from first accepted byte until computation_done is taken

## Operation

- One clock. Reset is asynchronous and active-high. All state, counters and operand registers clear on rst.
- Reset values: state IDLE, in_ready=1, all a*/b*=0, all active_*=0, busy=0, mode latch=00.
- Transfer occurs when in_valid & in_ready at a rising edge. Idle cycles between bytes (in_valid=0) are allowed anywhere in the frame.
- Frame = 25 bytes, row-major: bytes 0..15 go to a11,a12,a13,a14,a21..a44; bytes 16..24 go to b11,b12,b13,b21..b33.
- FSM states:
  - IDLE: in_ready=1. An accepted byte writes a11, latches in_mode, sets cnt=1, goes to LOAD_A.
  - LOAD_A: in_ready=1. Each accepted byte writes A[cnt] and increments cnt. Accepting byte 15 goes to LOAD_B with cnt=0.
  - LOAD_B: in_ready=1. Each accepted byte writes B[cnt]. Accepting byte 8 goes to ISSUE.
  - ISSUE: in_ready=0. The active_* line selected by the latched mode is 1 for this single cycle. Next state is WAIT.
  - WAIT: in_ready=0. a*/b* are held constant. When computation_done=1 the FSM goes to IDLE and busy falls.
- computation_done outside WAIT is ignored, including in ISSUE.
- in_mode is ignored except on the first byte of a frame.
- Operand registers are never cleared between frames. Each new frame overwrites them progressively.
- Counter is 4 bits. It never wraps, because the state transitions on the terminal count.
- Reset asserted mid-frame or mid-WAIT aborts immediately. No active_* pulse is produced and the partial frame is discarded.

## Timing

- If the last B byte is accepted at edge N, active_* is high during cycle N..N+1 (registered) and WAIT starts at edge N+1.
- If computation_done is sampled high at edge M in WAIT, in_ready=1 from edge M, so the next frame's byte can be accepted at edge M+1.
- Minimum frame period: 25 accept cycles + 1 ISSUE + WAIT length.
- Each a*/b* register updates at the accepting edge and is visible the following cycle.
- busy rises at the edge accepting byte 0 and falls at the edge where computation_done is taken.

## Structure

- Shared package conv_pkg:
  - state enum {IDLE, LOAD_A, LOAD_B, ISSUE, WAIT}
  - mode constants MODE_STORE=2'b00, MODE_SINGLE=2'b01, MODE_SA3=2'b10, MODE_SA2=2'b11
  - A_LEN=16, B_LEN=9
- The computation module should import the same package.
- Natural sub-module: conv_operand_regs. It holds 25 byte registers with write enable, index and region select (A/B), and exposes them flat.
- The FSM, counter and mode latch stay in the top module.

## Test plan

- Back-to-back frame: bytes 1..25, in_mode=01 on byte 0 -> a11=1, a44=16, b11=17, b33=25; active_single pulses exactly one cycle, one cycle after byte 25; in_ready=0 until computation_done.
- Gapped stream: same data with in_valid toggling 1/0 -> identical register contents; pulse timing is relative to the last accepted byte.
- Mode change mid-frame: in_mode=10 on byte 0, then 11 for the rest -> only active_sa3 pulses.
- computation_done=1 during LOAD_A and during ISSUE -> no effect; in WAIT, done held 3 cycles -> single return to IDLE and the next frame is accepted normally.
- Reset during byte 20 of the frame -> all outputs read 0 the next cycle, no active_* pulse, in_ready=1.
- Two consecutive frames with modes 00 then 11, second data 0xFF..0xE7 -> active_store then active_sa2 pulse; a11=0xFF, b33=0xE7 after the second frame.
